// File: rtl/lz77_stream_encoder_if.sv
// Char-in / token-out handshake bundle for the LZ77 stream encoder.
// The encoder takes the slave side; the char source and token sink take the master side.
interface lz77_stream_encoder_if #(
    parameter int CHAR_W = 8,
    parameter int OFF_W  = 4,
    parameter int LEN_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [CHAR_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  match_len;
    logic [CHAR_W-1:0] char_nxt;
    logic              out_last;
    logic              finish;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, offset, match_len, char_nxt, out_last, finish
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, offset, match_len, char_nxt, out_last, finish
    );
endinterface

// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 encoder: sliding window of SEARCH_W history + LOOK_W lookahead,
// one candidate distance tested per cycle, tokens (offset,len,next char) out.
module lz77_stream_encoder #(
    parameter int CHAR_W   = 8,
    parameter int SEARCH_W = 9,
    parameter int LOOK_W   = 8,
    parameter int OFF_W    = 4,
    parameter int LEN_W    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    lz77_stream_encoder_if.slave   io_bus
);
    localparam int N  = SEARCH_W + LOOK_W;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {ST_FILL, ST_SCAN, ST_EMIT, ST_SHIFT, ST_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CHAR_W-1:0] r_win [N];
    logic [CHAR_W-1:0] w_win_sh [N];
    logic [CW-1:0]     r_hist, r_la, r_d, r_best_d, r_best_l;
    logic [CW-1:0]     w_hist_nxt, w_la_nxt, w_cap, w_cand_l, w_sel_l, w_sel_d;
    logic [CW-1:0]     w_shift, w_hist_sum;
    logic              r_last_seen, w_last_nxt, r_tok_last;
    logic              w_in_hs, w_out_hs, w_run, w_better, w_scan_end;

    logic              r_in_ready, r_out_valid, r_out_last, r_finish;
    logic [OFF_W-1:0]  r_offset;
    logic [LEN_W-1:0]  r_len;
    logic [CHAR_W-1:0] r_char;

    assign w_in_hs  = io_bus.in_valid && r_in_ready;
    assign w_out_hs = r_out_valid && io_bus.out_ready;
    assign w_cap    = r_la - CW'(1);
    assign w_shift  = r_best_l + CW'(1);

    // History lives at r_win[SEARCH_W-1 downto], lookahead at r_win[SEARCH_W +: LOOK_W];
    // a candidate at distance d reads r_win[SEARCH_W-d+i], which may run into the lookahead.
    always_comb begin
        w_cand_l = '0;
        w_run    = (r_hist != '0);
        for (int i = 0; i < LOOK_W - 1; i++) begin
            if (w_run && (CW'(i) < w_cap) &&
                (r_win[CW'(SEARCH_W + i) - r_d] == r_win[SEARCH_W + i]))
                w_cand_l = w_cand_l + CW'(1);
            else
                w_run = 1'b0;
        end
    end

    // Strictly-greater replacement keeps the smallest distance on ties.
    assign w_better   = (w_cand_l > r_best_l);
    assign w_sel_l    = w_better ? w_cand_l : r_best_l;
    assign w_sel_d    = w_better ? r_d : r_best_d;
    assign w_scan_end = (r_d >= r_hist) || (w_sel_l == w_cap);
    assign w_hist_sum = r_hist + w_shift;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_win_sh[i] = '0;
            for (int k = 1; k <= LOOK_W; k++)
                if (w_shift == CW'(k) && (i + k) < N) w_win_sh[i] = r_win[(i + k) % N];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_la_nxt    = r_la;
        w_last_nxt  = r_last_seen;
        case (r_state)
            ST_FILL: begin
                if (w_in_hs) begin
                    w_la_nxt = r_la + CW'(1);
                    if (io_bus.in_last) w_last_nxt = 1'b1;
                end
                if (r_la == CW'(LOOK_W) || (r_last_seen && r_la != '0)) w_state_nxt = ST_SCAN;
            end
            ST_SCAN:  if (w_scan_end) w_state_nxt = ST_EMIT;
            ST_EMIT:  if (w_out_hs) w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                w_la_nxt    = r_la - w_shift;
                w_hist_nxt  = (w_hist_sum > CW'(SEARCH_W)) ? CW'(SEARCH_W) : w_hist_sum;
                w_state_nxt = r_tok_last ? ST_DONE : ST_FILL;
            end
            ST_DONE: begin
                w_hist_nxt  = '0;
                w_la_nxt    = '0;
                w_last_nxt  = 1'b0;
                w_state_nxt = ST_FILL;
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) r_win[i] <= '0;
        end else if (r_state == ST_FILL && w_in_hs) begin
            r_win[CW'(SEARCH_W) + r_la] <= io_bus.in_data;
        end else if (r_state == ST_SHIFT) begin
            r_win <= w_win_sh;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_FILL;
            r_hist      <= '0;
            r_la        <= '0;
            r_last_seen <= 1'b0;
            r_d         <= '0;
            r_best_d    <= '0;
            r_best_l    <= '0;
            r_tok_last  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_offset    <= '0;
            r_len       <= '0;
            r_char      <= '0;
            r_out_last  <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hist      <= w_hist_nxt;
            r_la        <= w_la_nxt;
            r_last_seen <= w_last_nxt;
            r_in_ready  <= (w_state_nxt == ST_FILL) && (w_la_nxt < CW'(LOOK_W)) && !w_last_nxt;
            r_finish    <= (w_state_nxt == ST_DONE);
            if (r_state == ST_FILL && w_state_nxt == ST_SCAN) begin
                r_d      <= CW'(1);
                r_best_d <= CW'(1);
                r_best_l <= '0;
            end
            if (r_state == ST_SCAN) begin
                r_d      <= r_d + CW'(1);
                r_best_d <= w_sel_d;
                r_best_l <= w_sel_l;
                if (w_scan_end) begin
                    r_out_valid <= 1'b1;
                    r_offset    <= (w_sel_l == '0) ? '0 : OFF_W'(w_sel_d - CW'(1));
                    r_len       <= LEN_W'(w_sel_l);
                    r_char      <= r_win[CW'(SEARCH_W) + w_sel_l];
                    r_out_last  <= r_last_seen && (r_la == w_sel_l + CW'(1));
                    r_tok_last  <= r_last_seen && (r_la == w_sel_l + CW'(1));
                end
            end
            if (r_state == ST_EMIT && w_out_hs) begin
                r_out_valid <= 1'b0;
                r_offset    <= '0;
                r_len       <= '0;
                r_char      <= '0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.offset    = r_offset;
    assign io_bus.match_len = r_len;
    assign io_bus.char_nxt  = r_char;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.finish    = r_finish;
endmodule

// File: tb/tb_lz77_stream_encoder.sv
// Scoreboard bench for lz77_stream_encoder: directed streams push expected tokens,
// a negedge monitor pops and compares each token handshake and checks stalls/finish.
module tb_lz77_stream_encoder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lz77_stream_encoder_if #(.CHAR_W(8), .OFF_W(4), .LEN_W(3)) bus ();

    lz77_stream_encoder #(
        .CHAR_W(8), .SEARCH_W(9), .LOOK_W(8), .OFF_W(4), .LEN_W(3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    typedef struct packed {
        logic [3:0] off;
        logic [2:0] len;
        logic [7:0] ch;
        logic       last;
    } tok_t;

    tok_t exp_q[$];
    tok_t cur, snap, e;
    int   n_tests = 0, n_fail = 0;
    int   tok_seen = 0, stall_at = -1, stall_left = 0;
    int   cyc = 0, fin_cnt = 0, last_hs_cyc = -100;
    bit   prev_stall = 0, prev_fin = 0;

    function automatic tok_t mk(int off, int len, byte ch, bit last);
        tok_t t;
        t.off  = off[3:0];
        t.len  = len[2:0];
        t.ch   = ch;
        t.last = last;
        return t;
    endfunction

    task automatic check(string name, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: drives out_ready (with optional stall) then scores the handshake.
    always @(negedge clk) begin
        cyc++;
        cur = {bus.offset, bus.match_len, bus.char_nxt, bus.out_last};
        if (!reset) begin
            bus.out_ready = 1'b1;
            prev_stall    = 0;
            prev_fin      = 0;
        end else begin
            if (bus.finish) begin
                fin_cnt++;
                check("finish_delay", cyc - last_hs_cyc, 2);
                check("finish_width", int'(prev_fin), 0);
            end
            prev_fin = bus.finish;
            if (bus.out_valid && tok_seen == stall_at && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_token: got %h, expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++;
                        $display("FAIL token%0d: got off=%0d len=%0d ch=%h last=%0d, expected off=%0d len=%0d ch=%h last=%0d",
                                 tok_seen, cur.off, cur.len, cur.ch, cur.last, e.off, e.len, e.ch, e.last);
                    end
                end
                if (bus.out_last) last_hs_cyc = cyc;
                tok_seen++;
                prev_stall = 0;
            end else if (bus.out_valid) begin
                if (prev_stall) check("stall_hold", int'(cur), int'(snap));
                check("stall_in_ready", int'(bus.in_ready), 0);
                snap       = cur;
                prev_stall = 1;
            end else begin
                check("idle_fields_zero", int'(cur), 0);
                prev_stall = 0;
            end
        end
    end

    task automatic send(byte c, bit last);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = c;
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            k++;
            if (k > 500) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1);
    endtask

    task automatic wait_finish(int target);
        int k = 0;
        while (fin_cnt < target && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("finish_count", fin_cnt, target);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(string name);
        check(name, int'({bus.out_valid, bus.in_ready, bus.finish, bus.offset,
                          bus.match_len, bus.char_nxt, bus.out_last}), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        int    k;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        exp_q.push_back(mk(0, 0, "a", 0));
        exp_q.push_back(mk(0, 2, "a", 1));
        send_str("aaaa");
        wait_finish(1);

        exp_q.push_back(mk(0, 0, "a", 0));
        exp_q.push_back(mk(0, 0, "b", 0));
        exp_q.push_back(mk(0, 0, "c", 0));
        exp_q.push_back(mk(2, 3, "d", 1));
        send_str("abcabcd");
        wait_finish(2);

        exp_q.push_back(mk(0, 0, "x", 0));
        exp_q.push_back(mk(0, 7, "x", 0));
        exp_q.push_back(mk(0, 7, "x", 0));
        exp_q.push_back(mk(0, 2, "x", 1));
        s = "";
        for (int i = 0; i < 20; i++) s = {s, "x"};
        send_str(s);
        wait_finish(3);

        stall_at   = tok_seen + 3;
        stall_left = 5;
        exp_q.push_back(mk(0, 0, "a", 0));
        exp_q.push_back(mk(0, 0, "b", 0));
        exp_q.push_back(mk(0, 0, "c", 0));
        exp_q.push_back(mk(2, 1, "b", 1));
        send_str("abcab");
        wait_finish(4);
        check("stall_consumed", stall_left, 0);

        exp_q.push_back(mk(0, 0, "a", 0));
        exp_q.push_back(mk(0, 0, "b", 1));
        exp_q.push_back(mk(0, 0, "a", 0));
        exp_q.push_back(mk(0, 0, "b", 1));
        send_str("ab");
        send_str("ab");
        wait_finish(6);

        // Reset during the scan that would produce the 4th token of "abcabc".
        exp_q.push_back(mk(0, 0, "a", 0));
        exp_q.push_back(mk(0, 0, "b", 0));
        exp_q.push_back(mk(0, 0, "c", 0));
        k = tok_seen;
        send_str("abcabc");
        begin
            int w = 0;
            while (!(tok_seen >= k + 3 && int'(dut.r_state) == 1) && w < 500) begin
                @(posedge clk);
                #1;
                w++;
            end
            check("reach_scan", int'(w < 500), 1);
        end
        reset = 1'b0;
        #1;
        check_outputs_zero("reset_in_scan");
        check("tokens_before_reset", tok_seen - k, 3);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_held");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 0, "a", 0));
        exp_q.push_back(mk(0, 0, "b", 0));
        exp_q.push_back(mk(0, 0, "c", 0));
        exp_q.push_back(mk(2, 2, "c", 1));
        send_str("abcabc");
        wait_finish(7);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
